// File: rtl/flow_mon_pkg.sv
// Shared types and constants for the multi-channel flit-flow monitor.
// Link word field offsets, title codes, stat selects, event record.
package flow_mon_pkg;

  localparam int LINK_W    = 66;
  localparam int TITLE_LSB = 64;
  localparam int PKT_LSB   = 48;
  localparam int SMALL_LSB = 32;
  localparam int PAY_LSB   = 0;

  typedef enum logic [1:0] {
    TITLE_IDLE = 2'b00,
    TITLE_HEAD = 2'b01,
    TITLE_BODY = 2'b10,
    TITLE_TAIL = 2'b11
  } title_e;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_INPKT = 1'b1
  } ch_state_e;

  localparam logic [2:0] SEL_HEAD  = 3'd0;
  localparam logic [2:0] SEL_BODY  = 3'd1;
  localparam logic [2:0] SEL_TAIL  = 3'd2;
  localparam logic [2:0] SEL_PKT   = 3'd3;
  localparam logic [2:0] SEL_ERR   = 3'd4;
  localparam logic [2:0] SEL_LAST  = 3'd5;
  localparam logic [2:0] SEL_MAX   = 3'd6;
  localparam logic [2:0] SEL_STATE = 3'd7;

  // Channel field is wide enough for any sane channel count;
  // the top slices it down to its own index width.
  localparam int EVT_CH_W = 8;

  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic [15:0]         pkt;
    logic [15:0]         lat;
  } evt_rec_t;

  function automatic logic [15:0] lat_calc(
    input logic [15:0] now,
    input logic [15:0] ts
  );
    return now - ts;
  endfunction

endpackage

// File: rtl/mon_evt_fifo.sv
// Synchronous FIFO for completed-packet event records.
// Ports: push/din/full write side, pop/dout/empty read side.
module mon_evt_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot a same-cycle push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/flow_monitor_mc.sv
// N-channel flit-flow monitor: framing FSM, stats, latency, event queue.
// Ports: data taps, clk_counter, clear, rd_ch/rd_sel/rd_data, evt_* stream.
module flow_monitor_mc
  import flow_mon_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_W      = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*LINK_W-1:0] data,
  input  logic [15:0]              clk_counter,
  input  logic                     clear,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [2:0]               rd_sel,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [CH_W-1:0]          evt_ch,
  output logic [15:0]              evt_pkt,
  output logic [15:0]              evt_lat,
  output logic [CNT_W-1:0]         evt_ovf
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] fit(
    input logic [15:0] v
  );
    logic [CNT_W+15:0] t;
    t = {{CNT_W{1'b0}}, v};
    return t[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] stat [NUM_CH][8];
  logic [NUM_CH-1:0] done;
  evt_rec_t          rec_now [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [LINK_W-1:0] link;
    logic [1:0]        title;
    logic [15:0]       pnum;
    logic              is_head;
    logic              is_body;
    logic              is_tail;
    ch_state_e         st;
    ch_state_e         st_nx;
    logic              capture;
    logic              complete;
    logic              err;
    logic [15:0]       ts_q;
    logic [15:0]       pkt_q;
    logic [15:0]       lat;
    logic [CNT_W-1:0]  head_c;
    logic [CNT_W-1:0]  body_c;
    logic [CNT_W-1:0]  tail_c;
    logic [CNT_W-1:0]  pkt_c;
    logic [CNT_W-1:0]  err_c;
    logic [15:0]       last_lat;
    logic [15:0]       max_lat;
    logic              unused_fields;

    assign link    = data[i*LINK_W +: LINK_W];
    assign title   = link[TITLE_LSB +: 2];
    assign pnum    = link[PKT_LSB +: 16];
    assign is_head = (title == TITLE_HEAD);
    assign is_body = (title == TITLE_BODY);
    assign is_tail = (title == TITLE_TAIL);
    assign lat     = lat_calc(clk_counter, ts_q);

    assign unused_fields = ^{link[SMALL_LSB +: 16], link[PAY_LSB +: 32]};

    always_comb begin
      st_nx    = st;
      capture  = 1'b0;
      complete = 1'b0;
      err      = 1'b0;
      unique case (st)
        CH_IDLE: begin
          if (is_head) begin
            st_nx   = CH_INPKT;
            capture = 1'b1;
          end else if (is_body || is_tail) begin
            err = 1'b1;
          end
        end
        CH_INPKT: begin
          // A second head abandons the open packet.
          if (is_head) begin
            err     = 1'b1;
            capture = 1'b1;
          end else if (is_tail) begin
            st_nx    = CH_IDLE;
            complete = 1'b1;
          end
        end
        default: st_nx = CH_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st    <= CH_IDLE;
        ts_q  <= '0;
        pkt_q <= '0;
      end else begin
        st <= st_nx;
        if (capture) begin
          ts_q  <= clk_counter;
          pkt_q <= pnum;
        end
      end
    end

    // Clear wins over any same-cycle count update.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head_c   <= '0;
        body_c   <= '0;
        tail_c   <= '0;
        pkt_c    <= '0;
        err_c    <= '0;
        last_lat <= '0;
        max_lat  <= '0;
      end else if (clear) begin
        head_c   <= '0;
        body_c   <= '0;
        tail_c   <= '0;
        pkt_c    <= '0;
        err_c    <= '0;
        last_lat <= '0;
        max_lat  <= '0;
      end else begin
        if (is_head) head_c <= sat_inc(head_c);
        if (is_body) body_c <= sat_inc(body_c);
        if (is_tail) tail_c <= sat_inc(tail_c);
        if (err)     err_c  <= sat_inc(err_c);
        if (complete) begin
          pkt_c    <= sat_inc(pkt_c);
          last_lat <= lat;
          if (lat > max_lat) max_lat <= lat;
        end
      end
    end

    assign done[i]    = complete;
    assign rec_now[i] = {EVT_CH_W'(i), pkt_q, lat};

    assign stat[i][SEL_HEAD]  = head_c;
    assign stat[i][SEL_BODY]  = body_c;
    assign stat[i][SEL_TAIL]  = tail_c;
    assign stat[i][SEL_PKT]   = pkt_c;
    assign stat[i][SEL_ERR]   = err_c;
    assign stat[i][SEL_LAST]  = fit(last_lat);
    assign stat[i][SEL_MAX]   = fit(max_lat);
    assign stat[i][SEL_STATE] = fit({15'd0, st == CH_INPKT});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_ch} < NUM_CH_L) begin
      rd_data <= stat[rd_ch][rd_sel];
    end else begin
      rd_data <= '0;
    end
  end

  logic [NUM_CH-1:0] pend_v;
  evt_rec_t          pend_rec [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] gnt_oh;
  logic [NUM_CH-1:0] drop;
  logic [CNT_W:0]    drop_cnt;
  logic [CNT_W:0]    ovf_sum;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              push_ok;
  evt_rec_t          fifo_dout;
  logic              unused_ch;

  assign fifo_pop = !fifo_empty && evt_ready;
  assign push_ok  = !fifo_full || fifo_pop;

  // Round-robin: first pending channel at or after rr_ptr.
  always_comb begin
    int c;
    c       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!gnt_any && pend_v[c]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(c);
      end
    end
    if (!push_ok) gnt_any = 1'b0;
  end

  // A record is dropped only if its pending slot stays occupied.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_oh[i] = gnt_any && (gnt_idx == CH_W'(i));
      drop[i]   = done[i] && pend_v[i] && !gnt_oh[i];
      drop_cnt  = drop_cnt + (CNT_W+1)'(drop[i]);
    end
    ovf_sum = {1'b0, evt_ovf} + drop_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v  <= '0;
      rr_ptr  <= '0;
      evt_ovf <= '0;
      for (int i = 0; i < NUM_CH; i++) pend_rec[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt_oh[i]) pend_v[i] <= 1'b0;
        if (done[i] && !drop[i]) begin
          pend_v[i]   <= 1'b1;
          pend_rec[i] <= rec_now[i];
        end
      end
      if (gnt_any) begin
        rr_ptr <= (gnt_idx == CH_W'(NUM_CH-1)) ?
                  '0 : gnt_idx + CH_W'(1);
      end
      evt_ovf <= ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
    end
  end

  mon_evt_fifo #(
    .WIDTH ($bits(evt_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_any),
    .din   (pend_rec[gnt_idx]),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_ch    = evt_valid ? fifo_dout.ch[CH_W-1:0] : '0;
  assign evt_pkt   = evt_valid ? fifo_dout.pkt : '0;
  assign evt_lat   = evt_valid ? fifo_dout.lat : '0;
  assign unused_ch = ^fifo_dout.ch;

endmodule
